pipe_credit_fifo: RTL and testbench

Credit-managed output buffer placed directly downstream of a fixed-latency `pipeline` delay stage. It tells the upstream issuer when it may launch a word into the pipeline, and captures every word emerging from the pipeline into a first-word-fall-through FIFO. It then hands each word to a valid/ready consumer. Credits guarantee that back-pressure from the consumer never drops a word already in flight.

---
 rtl/pipe_credit_fifo.sv | 128 ++++++++++++
 tb/tb_pipe_credit_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_credit_fifo.sv
// ---------------------------------------------------------------------------
// pipe_credit_fifo
//
// Output buffer for a fixed-latency upstream pipeline. A credit counter
// (one credit per FIFO entry) gates the issuer, so every word launched into
// the pipeline is guaranteed a slot when it emerges, however long the
// consumer stalls. Arriving words land in a first-word-fall-through FIFO
// that feeds a valid/ready consumer.
//
// Ports
//   clk_in           clock, all state on its rising edge
//   rst_in           asynchronous reset, active low
//   issue_ready_out  a credit is available; issuer may launch this cycle
//   issue_valid_in   issuer launches a word (fires with issue_ready_out)
//   data_valid_in    a word is emerging from the pipeline this cycle
//   data_in          that word
//   valid_out        FIFO head is valid
//   data_out         FIFO head, 0 when valid_out is low
//   ready_in         consumer accepts the head (pops with valid_out)
//   count_out        FIFO occupancy
//   inflight_out     words issued but not yet arrived
//   error_out        sticky: [0] overflow drop, [1] arrival with nothing in flight
// ---------------------------------------------------------------------------
module pipe_credit_fifo #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    output logic                       issue_ready_out,
    input  logic                       issue_valid_in,
    input  logic                       data_valid_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic [$clog2(DEPTH+1)-1:0] inflight_out,
    output logic [1:0]                 error_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Issue -> arrival -> pop -> credit back takes LATENCY+2 cycles. A FIFO
    // shallower than that still works correctly but cannot stream one word
    // per cycle; nothing in the logic depends on it.
    if (DEPTH < LATENCY + 2) begin : g_rate_limited
    end

    logic [CW-1:0]    credits;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [1:0]       error;
    logic [WIDTH-1:0] mem [DEPTH];

    logic fire;
    logic pop;
    logic push;
    logic full;
    logic overflow;
    logic spurious;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Ready comes straight from the credit register, so the issuer sees no
    // combinational path from any input of this block.
    assign issue_ready_out = (credits != '0);
    assign valid_out       = (count != '0);
    assign fire            = issue_valid_in & issue_ready_out;
    assign pop             = valid_out & ready_in;
    assign full            = (count == FULL);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push            = data_valid_in & (~full | pop);
    assign overflow        = data_valid_in & full & ~pop;
    assign spurious        = data_valid_in & (inflight == '0);

    assign data_out     = valid_out ? mem[rd_ptr] : '0;
    assign count_out    = count;
    assign inflight_out = inflight;
    assign error_out    = error;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like the flops.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            credits  <= FULL;
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            error    <= '0;
        end else begin
            credits <= credits - CW'(fire) + CW'(pop);
            count   <= count + CW'(push) - CW'(pop);
            // An arrival with nothing in flight is flagged, not subtracted,
            // so the counter never wraps below zero.
            if (spurious) begin
                inflight <= inflight + CW'(fire);
            end else begin
                inflight <= inflight + CW'(fire) - CW'(data_valid_in);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            error <= error | {spurious, overflow};
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it was written, and count/pointers (which are reset) decide that.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_credit_fifo
//
// Drives pipe_credit_fifo (DEPTH=4, LATENCY=2) from a behavioural 2-stage
// upstream delay line. Every launched word is pushed to a scoreboard queue
// and popped/compared whenever the consumer takes the FIFO head. A monitor
// also checks the credit invariant (credits + inflight + count = DEPTH, seen
// as issue_ready_out == inflight+count != DEPTH) and the in-flight count
// against the delay line occupancy.
// ---------------------------------------------------------------------------
module tb_pipe_credit_fifo;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;
    localparam int CW      = $clog2(DEPTH + 1);

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             issue_ready_out;
    logic             issue_valid_in;
    logic             data_valid_in;
    logic [WIDTH-1:0] data_in;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic             ready_in;
    logic [CW-1:0]    count_out;
    logic [CW-1:0]    inflight_out;
    logic [1:0]       error_out;

    // Directed injection of words that bypass the delay line.
    logic             force_v;
    logic [WIDTH-1:0] force_d;
    logic             inv_en;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb [$];

    pipe_credit_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .issue_ready_out (issue_ready_out),
        .issue_valid_in  (issue_valid_in),
        .data_valid_in   (data_valid_in),
        .data_in         (data_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .ready_in        (ready_in),
        .count_out       (count_out),
        .inflight_out    (inflight_out),
        .error_out       (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Upstream: LATENCY-stage delay line, reset by the same net as the DUT.
    logic [LATENCY-1:0] pv;
    logic [WIDTH-1:0]   pd [LATENCY];
    logic [WIDTH-1:0]   next_word;
    wire                up_fire = issue_valid_in & issue_ready_out;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pv        <= '0;
            next_word <= '0;
        end else begin
            pv    <= {pv[LATENCY-2:0], up_fire};
            pd[0] <= next_word;
            for (int i = 1; i < LATENCY; i++) pd[i] <= pd[i-1];
            if (up_fire) begin
                next_word <= next_word + 8'd1;
                sb.push_back(next_word);
            end
        end
    end

    assign data_valid_in = pv[LATENCY-1] | force_v;
    assign data_in       = force_v ? force_d : pd[LATENCY-1];

    // Inputs change 1 time unit after a rising edge, so the falling edge sees
    // exactly what the next rising edge will sample.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (valid_out && ready_in) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) check("pop_data", data_out, sb.pop_front());
            end
            if (inv_en) begin
                check("credit_inv", issue_ready_out, 32'((inflight_out + count_out) != DEPTH));
                check("inflight", inflight_out, $countones(pv));
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((count_out != 0 || inflight_out != 0) && n < 60) begin
            tick();
            n++;
        end
        check(tag, count_out, 0);
        check({tag, "_sb"}, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int fired;
        int drops;
        int first;
        int t;

        issue_valid_in = 1'b0;
        ready_in       = 1'b0;
        force_v        = 1'b0;
        force_d        = '0;
        inv_en         = 1'b0;
        rst_in         = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;
        tick();
        check("rst_ready", issue_ready_out, 1);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_count", count_out, 0);
        check("rst_inflight", inflight_out, 0);
        check("rst_error", error_out, 2'b00);
        inv_en = 1'b1;

        // Streaming: 20 words back-to-back, consumer always ready
        ready_in       = 1'b1;
        issue_valid_in = 1'b1;
        fired = 0; drops = 0; first = -1; t = 0;
        while (fired < 20 && t < 100) begin
            if (issue_ready_out) fired++;
            else drops++;
            tick();
            t++;
            if (valid_out && first < 0) first = t;
        end
        issue_valid_in = 1'b0;
        check("stream_fired", fired, 20);
        check("stream_drops", drops, 0);
        check("stream_latency", first, 3);
        drain("stream_drain");

        // Back-pressure: consumer stalled, issuer always valid
        ready_in       = 1'b0;
        issue_valid_in = 1'b1;
        fired = 0;
        repeat (10) begin
            if (issue_ready_out) fired++;
            tick();
        end
        check("bp_fires", fired, 4);
        check("bp_count", count_out, 4);
        check("bp_ready", issue_ready_out, 0);
        check("bp_error", error_out, 2'b00);
        ready_in = 1'b1;
        tick();
        check("bp_resume", issue_ready_out, 1);
        issue_valid_in = 1'b0;
        drain("bp_drain");

        // Simultaneous push and pop at count=1 (words 0x18 then 0x19)
        ready_in       = 1'b0;
        issue_valid_in = 1'b1;
        tick();
        issue_valid_in = 1'b0;
        repeat (3) tick();
        check("sim_count0", count_out, 1);
        check("sim_head0", data_out, 8'h18);
        issue_valid_in = 1'b1;
        tick();
        issue_valid_in = 1'b0;
        tick();
        ready_in = 1'b1;
        check("sim_count1", count_out, 1);
        check("sim_head1", data_out, 8'h18);
        tick();
        check("sim_count2", count_out, 1);
        check("sim_head2", data_out, 8'h19);
        drain("sim_drain");

        // Spurious arrival, then overflow (upstream deliberately misbehaves)
        ready_in = 1'b0;
        inv_en   = 1'b0;
        force_v  = 1'b1;
        force_d  = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        force_v = 1'b0;
        check("spur_error", error_out, 2'b10);
        check("spur_count", count_out, 1);
        check("spur_inflight", inflight_out, 0);
        check("spur_head", data_out, 8'hA5);
        for (int i = 1; i <= 3; i++) begin
            force_v = 1'b1;
            force_d = 8'hB0 + 8'(i);
            sb.push_back(8'hB0 + 8'(i));
            tick();
        end
        force_d = 8'hEE;
        tick();
        force_v = 1'b0;
        check("ovf_error", error_out, 2'b11);
        check("ovf_count", count_out, 4);
        check("ovf_head", data_out, 8'hA5);
        ready_in = 1'b1;
        drain("ovf_drain");
        repeat (3) tick();
        check("ovf_sticky", error_out, 2'b11);

        // Clean reset before the mid-burst test
        rst_in = 1'b0;
        sb.delete();
        tick();
        rst_in = 1'b1;
        tick();
        check("clr_error", error_out, 2'b00);
        inv_en   = 1'b1;
        ready_in = 1'b0;

        // Mid-burst asynchronous reset with count=2, inflight=1
        issue_valid_in = 1'b1;
        fired = 0; t = 0;
        while (!(count_out == 2 && inflight_out == 1) && t < 20) begin
            if (issue_valid_in && issue_ready_out) fired++;
            tick();
            t++;
            if (fired == 3) issue_valid_in = 1'b0;
        end
        issue_valid_in = 1'b0;
        check("mid_count", count_out, 2);
        check("mid_inflight", inflight_out, 1);
        rst_in = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_ready", issue_ready_out, 1);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_count", count_out, 0);
        check("mid_rst_inflight", inflight_out, 0);
        check("mid_rst_error", error_out, 2'b00);
        repeat (2) tick();
        rst_in = 1'b1;
        tick();
        ready_in       = 1'b1;
        issue_valid_in = 1'b1;
        repeat (2) tick();
        issue_valid_in = 1'b0;
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
